// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces whole-keypad snapshots and reports single new key presses as hex codes.
module keypad_scanner #(
   parameter int CLK_FREQ_HZ    = 100_000_000,
   parameter int SCAN_PERIOD_US = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int COL_DWELL = (CLK_FREQ_HZ / 1_000_000) * SCAN_PERIOD_US;
   localparam int CW        = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
   localparam logic [CW-1:0] DWELL_LAST = CW'(COL_DWELL - 1);
   localparam logic [3:0]    MATCH_MAX  = 4'(DEBOUNCE_SCANS);

   // The sample point must sit after the two-flop synchronizer has settled on
   // the newly strobed column, so very short dwells are refused.
   if (COL_DWELL < 4) begin : g_bad_dwell
      $error("keypad_scanner: COL_DWELL must be >= 4");
   end
   if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
      $error("keypad_scanner: DEBOUNCE_SCANS must be in 1..15");
   end

   logic [3:0]    row_meta;
   logic [3:0]    row_sync;
   logic [3:0]    pressed;
   logic [CW-1:0] dwell;
   logic [1:0]    idx;
   logic [1:0]    idx_next;
   logic          sample;
   logic          scan_done;
   logic [15:0]   work;
   logic [15:0]   work_next;
   logic [15:0]   cand;
   logic [15:0]   cand_next;
   logic [15:0]   stable;
   logic [3:0]    match;
   logic [3:0]    match_next;
   logic          accept;
   logic          key_event;

   // Snapshot bit 4*r+c maps to the legend printed on that key.
   function automatic logic [3:0] map_key(input logic [15:0] snap);
      logic [3:0] code;
      code = 4'h0;
      case (snap)
         16'h0001: code = 4'h1;
         16'h0002: code = 4'h2;
         16'h0004: code = 4'h3;
         16'h0008: code = 4'hA;
         16'h0010: code = 4'h4;
         16'h0020: code = 4'h5;
         16'h0040: code = 4'h6;
         16'h0080: code = 4'hB;
         16'h0100: code = 4'h7;
         16'h0200: code = 4'h8;
         16'h0400: code = 4'h9;
         16'h0800: code = 4'hC;
         16'h1000: code = 4'h0;
         16'h2000: code = 4'hF;
         16'h4000: code = 4'hE;
         16'h8000: code = 4'hD;
         default:  code = 4'h0;
      endcase
      return code;
   endfunction

   // Rows are asynchronous to clk; idle (pulled-up) value is all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   assign pressed   = ~row_sync;
   assign sample    = (dwell == DWELL_LAST);
   assign scan_done = sample && (idx == 2'd3);
   assign idx_next  = idx + 2'd1;

   // Dwell timer and column strobe; the strobe moves on the same edge as the index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell <= '0;
         idx   <= 2'd0;
         col   <= 4'b1110;
      end else if (sample) begin
         dwell <= '0;
         idx   <= idx_next;
         col   <= ~(4'b0001 << idx_next);
      end else begin
         dwell <= dwell + CW'(1);
      end
   end

   // Merge the current column's rows into the working snapshot at the sample point.
   always_comb begin
      work_next = work;
      if (sample) begin
         for (int r = 0; r < 4; r++) begin
            work_next[4*r + int'(idx)] = pressed[r];
         end
      end
   end

   // Scan-level debounce: count consecutive identical complete snapshots.
   always_comb begin
      cand_next  = cand;
      match_next = match;
      if (scan_done) begin
         if (work_next == cand) begin
            match_next = (match == MATCH_MAX) ? MATCH_MAX : match + 4'd1;
         end else begin
            cand_next  = work_next;
            match_next = 4'd1;
         end
      end
   end

   assign accept    = scan_done && (match_next == MATCH_MAX);
   assign key_event = accept && (stable == 16'h0) && $onehot(cand_next);

   // Working snapshot register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work <= 16'h0;
      end else begin
         work <= work_next;
      end
   end

   // Candidate, match count and accepted (stable) keypad state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand   <= 16'h0;
         match  <= 4'd0;
         stable <= 16'h0;
      end else begin
         cand  <= cand_next;
         match <= match_next;
         if (accept) begin
            stable <= cand_next;
         end
      end
   end

   // Only a lone key appearing from an all-released keypad is reported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         key_valid <= key_event;
         if (key_event) begin
            key_code <= map_key(cand_next);
         end
         key_held <= (stable != 16'h0);
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random keypad patterns against a scan-level
// history model of the debounce and event rules.
module tb_keypad_scanner;

   localparam int DS   = 2;
   localparam int SCAN = 32;

   logic       clk;
   logic       rst_n;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys;
   int          n_checks;
   int          n_fail;

   logic [15:0] hist[$];
   logic [15:0] m_stable;
   logic [3:0]  m_code;
   logic [63:0] ctab;

   keypad_scanner #(
      .CLK_FREQ_HZ   (4_000_000),
      .SCAN_PERIOD_US(2),
      .DEBOUNCE_SCANS(DS)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .row      (row),
      .col      (col),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key shorts its row to its column when that column is strobed low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         row[r] = ~(|(keys[4*r +: 4] & ~col));
      end
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] code_of(input logic [15:0] k);
      int b;
      b = 0;
      for (int i = 0; i < 16; i++) if (k[i]) b = i;
      return ctab[4*b +: 4];
   endfunction

   task automatic model_reset();
      hist.delete();
      m_stable = 16'h0;
      m_code   = 4'h0;
   endtask

   // One full 32-clock scan with key set k held throughout.
   task automatic run_scan(input logic [15:0] k);
      logic       exp_ev;
      logic       held_before;
      logic       all_same;
      logic [3:0] ec;
      keys        = k;
      held_before = (m_stable != 16'h0);
      exp_ev      = 1'b0;
      hist.push_back(k);
      if (hist.size() > DS) void'(hist.pop_front());
      all_same = (hist.size() == DS);
      foreach (hist[j]) if (hist[j] != k) all_same = 1'b0;
      if (all_same) begin
         if (m_stable == 16'h0 && $countones(k) == 1) begin
            exp_ev = 1'b1;
            m_code = code_of(k);
         end
         m_stable = k;
      end
      for (int i = 0; i < SCAN; i++) begin
         @(posedge clk);
         #1;
         ec = ~(4'b0001 << (((i + 1) / 8) % 4));
         chk("col", 16'(col), 16'(ec));
         if (i == 0) chk("key_held", 16'(key_held), 16'(held_before));
         chk("key_valid", 16'(key_valid), 16'((i == SCAN - 1) && exp_ev));
         if (i == SCAN - 1) chk("key_code", 16'(key_code), 16'(m_code));
      end
   endtask

   initial begin
      logic [15:0] k;
      int          sel;
      int          a;
      int          b;
      n_checks = 0;
      n_fail   = 0;
      ctab     = 64'hDEF0_C987_B654_A321;
      keys     = 16'h0;
      rst_n    = 1'b0;
      model_reset();

      #22;
      chk("rst_col", 16'(col), 16'(4'b1110));
      chk("rst_key_code", 16'(key_code), 16'h0);
      chk("rst_key_valid", 16'(key_valid), 16'h0);
      chk("rst_key_held", 16'(key_held), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // idle scans
      repeat (2) run_scan(16'h0);
      // hold "6" for a long time: one event only
      repeat (12) run_scan(16'h0040);
      repeat (3) run_scan(16'h0);
      // bouncing "9"
      repeat (4) begin
         run_scan(16'h0400);
         run_scan(16'h0);
      end
      run_scan(16'h0);
      // "6" then release then "0"
      repeat (3) run_scan(16'h0040);
      repeat (3) run_scan(16'h0);
      repeat (4) run_scan(16'h1000);
      repeat (3) run_scan(16'h0);
      // "1"+"5" together, then only "5"
      repeat (3) run_scan(16'h0021);
      repeat (3) run_scan(16'h0020);
      repeat (3) run_scan(16'h0);
      // re-press same key after release
      repeat (3) run_scan(16'h0020);
      repeat (3) run_scan(16'h0);
      repeat (3) run_scan(16'h0020);

      // random key patterns with random run lengths
      repeat (30) begin
         sel = int'($urandom_range(0, 3));
         a   = int'($urandom_range(0, 15));
         b   = (a + int'($urandom_range(1, 15))) % 16;
         k   = 16'h0;
         if (sel == 1 || sel == 2) k[a] = 1'b1;
         if (sel == 3) begin
            k[a] = 1'b1;
            k[b] = 1'b1;
         end
         repeat (int'($urandom_range(1, 3))) run_scan(k);
      end

      // hold "A" to get known non-zero outputs, then reset mid column-2 dwell with "D" held
      repeat (3) run_scan(16'h0);
      repeat (3) run_scan(16'h0008);
      chk("pre_rst_held", 16'(key_held), 16'h1);
      keys = 16'h8000;
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_col", 16'(col), 16'(4'b1110));
      chk("async_rst_key_code", 16'(key_code), 16'h0);
      chk("async_rst_key_valid", 16'(key_valid), 16'h0);
      chk("async_rst_key_held", 16'(key_held), 16'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hold_col", 16'(col), 16'(4'b1110));
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (5) run_scan(16'h8000);
      @(posedge clk);
      #1;
      chk("final_key_held", 16'(key_held), 16'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
